// File: rtl/shared_counter_arbiter.sv
// Round-robin arbiter sharing one up-counter between N_REQ timed-interval requesters.
// Define SHARED_COUNTER_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module shared_counter_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] len,
    output logic [N_REQ-1:0]       gnt,
    output logic [2:0]             gnt_id,
    output logic                   busy,
    output logic [CNT_W-1:0]       count,
    output logic [N_REQ-1:0]       done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       ptr;
    logic [2:0]       ptr_nxt;
    logic [2:0]       gnt_id_nxt;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] target_nxt;
    logic [CNT_W-1:0] count_nxt;

    logic [2:0]       sel;
    logic             sel_vld;
    logic [CNT_W-1:0] sel_len;
    logic             cur_req;
    int unsigned      best_d;

    // Search distance of requester i from the slot just after the pointer.
    function automatic int unsigned arb_dist(input int unsigned i, input logic [2:0] p);
`ifdef SHARED_COUNTER_ARB_FIXED_PRIO_EN
        return i;
`else
        return (i + N_REQ - 1 - 32'(p)) % N_REQ;
`endif
    endfunction

    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        best_d  = N_REQ;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req[i] && (arb_dist(i, ptr) < best_d)) begin
                best_d  = arb_dist(i, ptr);
                sel     = 3'(i);
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        sel_len = '0;
        cur_req = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (sel == 3'(i)) begin
                sel_len = len[i*CNT_W +: CNT_W];
            end
            if (gnt_id == 3'(i)) begin
                cur_req = req[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ptr    <= 3'(N_REQ - 1);
            gnt_id <= '0;
            target <= '0;
            count  <= '0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            gnt_id <= gnt_id_nxt;
            target <= target_nxt;
            count  <= count_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        gnt_id_nxt = gnt_id;
        target_nxt = target;
        count_nxt  = count;
        case (state)
            IDLE: begin
                count_nxt = '0;
                if (sel_vld) begin
                    gnt_id_nxt = sel;
                    target_nxt = sel_len;
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                // Abort wins over completion: a dropped request never sees done.
                if (!cur_req) begin
                    count_nxt = '0;
                    state_nxt = IDLE;
`ifndef SHARED_COUNTER_ARB_FIXED_PRIO_EN
                    ptr_nxt   = gnt_id;
`endif
                end else if (count == target) begin
                    state_nxt = DONE;
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end
            DONE: begin
                count_nxt = '0;
                state_nxt = IDLE;
`ifndef SHARED_COUNTER_ARB_FIXED_PRIO_EN
                ptr_nxt   = gnt_id;
`endif
            end
            default: begin
                count_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt  = '0;
        done = '0;
        busy = (state != IDLE);
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (busy && (gnt_id == 3'(i))) begin
                gnt[i] = 1'b1;
            end
        end
        if (state == DONE) begin
            done = gnt;
        end
    end

endmodule

// File: doc/shared_counter_arbiter.md
Name: shared_counter_arbiter

Overview:
- Shares one CNT_W-bit up-counter between N_REQ requesters, each of which needs a timed interval of a programmed length.
- Round-robin arbitration selects one requester at a time.
- For the granted requester, the block captures its length, runs the counter from 0 to that length, then pulses a per-requester done.
- Sits between the requesting control blocks and the counter datapath, and sequences that counter.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CNT_W, 4, counter and length width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester request level; must be held until done or abort.
- len  input  N_REQ*CNT_W  packed lengths; requester i uses bits [i*CNT_W +: CNT_W].
- gnt  output  N_REQ  one-hot grant, high for the whole of RUN and DONE.
- gnt_id  output  3  index of the current or most recent grantee.
- busy  output  1  high while in RUN or DONE.
- count  output  CNT_W  live counter value.
- done  output  N_REQ  one-cycle completion pulse to the grantee.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; gnt=0, done=0, busy=0, count=0, gnt_id=0.
  - Round-robin pointer = N_REQ-1, so requester 0 has first priority after reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If req != 0, select the first set bit searching upward from pointer+1 with wrap.
  - At the next edge: gnt=onehot(sel), gnt_id=sel, target<=len[sel], count<=0, state=RUN.
  - If req == 0, remain in IDLE; count holds 0.
- RUN:
  - Each edge: if count==target, go to DONE; otherwise count<=count+1.
  - Run length is target+1 cycles; len=0 gives 1 RUN cycle.
  - len=2^CNT_W-1 reaches the maximum value. count never wraps.
- DONE (exactly 1 cycle):
  - done[gnt_id]=1; count holds target.
  - Next edge: gnt=0, done=0, count=0, pointer=gnt_id, state=IDLE.
- Grant latency:
  - Request seen in IDLE at edge k: gnt valid after edge k; done after edge k+target+1.
  - Minimum spacing between consecutive grants is 1 IDLE cycle, so two back-to-back requesters have one bubble cycle between them.
- len is sampled only at grant. Later changes to len have no effect on the running interval.
- Abort: if req[gnt_id] drops in RUN, the next edge performs gnt=0, count=0, pointer=gnt_id, state=IDLE, with no done pulse.
- Simultaneous requests: exactly one is granted per arbitration. The others wait and are served in round-robin order. No requester starves: the maximum wait is (N_REQ-1) intervals.
- A new req rising in any state is only considered in IDLE.
- Reset asserted mid-RUN clears everything immediately and asynchronously. No done pulse is produced.
- gnt is always one-hot or zero. done is a subset of gnt.

Optional Feature:
- Macro: SHARED_COUNTER_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The pointer is not updated and gnt_id still reports the grantee.
- Undefined (default): round-robin as described above.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> gnt=0, busy=0, count=0, done=0. Assert rst=0 mid-RUN (count=3) -> all outputs 0 at once, with no clock edge needed.
- Single requester: req=0001, len0=5 -> gnt=0001 one edge later; count steps 0..5 over 6 cycles; done[0] pulses on the 7th cycle; count=0 afterwards.
- Round-robin: req=1111 held, all lens=1 -> grant order 0,1,2,3,0; each interval is 2 RUN + 1 DONE + 1 IDLE cycles.
- Boundaries: len=0 -> 1 RUN cycle, then done. len=15 -> count reaches 15 with no wrap and done fires after 16 RUN cycles.
- Abort: req=0100, len2=9, drop req[2] at count=4 -> gnt=0 and count=0 next edge, no done; next grant searches from index 3.
- With SHARED_COUNTER_ARB_FIXED_PRIO_EN defined: req=1010 held -> requester 1 is granted every time and requester 3 never.
